// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
//   - bht_state_e : 2-bit saturating counter states (SNT, WNT, WT, ST)
//   - BHT_RESET   : counter value loaded on reset
//   - F3_*        : conditional-branch funct3 codes, shared with the comparator
//   - DEFAULT_INDEX_BITS : default table index width
//   - bht_next()  : saturating counter update
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = WNT;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned DEFAULT_INDEX_BITS = 6;

    function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
        logic [1:0] raw;
        raw = state;
        if (taken) begin
            if (raw != 2'b11) raw = raw + 2'd1;
        end else begin
            if (raw != 2'b00) raw = raw - 2'd1;
        end
        return bht_state_e'(raw);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_array.sv
// Branch history table: 2^INDEX_BITS entries of 2-bit saturating counters.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset (all entries -> WNT)
//   i_rd_idx / o_rd_state : asynchronous read port
//   i_wr_en, i_wr_idx     : synchronous update port
//   i_wr_taken            : update direction (1 = increment, 0 = decrement, saturating)
// A read of the index being written returns the pre-update value.
module bht_array
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic [1:0]            o_rd_state,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic                  i_wr_taken
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    bht_state_e table_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            table_q[i_wr_idx] <= bht_next(table_q[i_wr_idx], i_wr_taken);
        end
    end

    always_comb begin
        o_rd_state = table_q[i_rd_idx];
    end

endmodule

// File: rtl/branch_predictor.sv
// Conditional-branch predictor with flush/redirect generation and event counters.
// Configuration macro: BRANCH_PREDICT_EN
//   defined   : dynamic prediction from a bht_array of 2-bit counters
//   undefined : no table, static not-taken prediction
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_stall             : blocks resolution, training and counting
//   i_id_branch, i_id_pc: ID-stage branch lookup
//   o_pred_taken        : ID prediction (suppressed while EX flushes)
//   i_ex_*              : EX-stage branch, PC, carried prediction, outcome, target
//   o_flush             : squash IF/ID
//   o_redirect_pc       : corrected fetch PC while o_flush is high, else 0
//   o_branch_count      : resolved branches
//   o_mispredict_count  : mispredicted branches
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_id_branch,
    input  logic [31:0] i_id_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_branch,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_pred_taken,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_branch_count,
    output logic [31:0] o_mispredict_count
);

    logic        resolve;
    logic        mispredict;
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    assign resolve = i_ex_branch & ~i_stall;

`ifdef BRANCH_PREDICT_EN
    logic [1:0] id_state;
    logic       unused_pc_bits;

    assign unused_pc_bits = ^{i_id_pc[31:INDEX_BITS+2], i_id_pc[1:0],
                              i_ex_pc[1:0], id_state[0]};

    bht_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_idx   (i_id_pc[INDEX_BITS+1:2]),
        .o_rd_state (id_state),
        .i_wr_en    (resolve),
        .i_wr_idx   (i_ex_pc[INDEX_BITS+1:2]),
        .i_wr_taken (i_ex_taken)
    );

    always_comb begin
        mispredict    = resolve & (i_ex_taken ^ i_ex_pred_taken);
        o_flush       = mispredict;
        o_redirect_pc = '0;
        if (mispredict) begin
            o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
        end
        // The ID instruction is squashed by an EX flush, so its prediction is dropped.
        o_pred_taken  = i_id_branch & id_state[1] & ~o_flush;
    end
`else
    logic unused_static_inputs;

    assign unused_static_inputs = ^{i_id_branch, i_id_pc, i_ex_pc, i_ex_pred_taken};

    // Static not-taken: every taken branch is a misprediction.
    always_comb begin
        mispredict    = resolve & i_ex_taken;
        o_flush       = mispredict;
        o_redirect_pc = mispredict ? i_ex_target : '0;
        o_pred_taken  = 1'b0;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (resolve) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (mispredict) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign o_branch_count     = branch_count_q;
    assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        id_branch;
    logic [31:0] id_pc;
    logic        pred_taken;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(
        .INDEX_BITS (6)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_stall            (stall),
        .i_id_branch        (id_branch),
        .i_id_pc            (id_pc),
        .o_pred_taken       (pred_taken),
        .i_ex_branch        (ex_branch),
        .i_ex_pc            (ex_pc),
        .i_ex_pred_taken    (ex_pred_taken),
        .i_ex_taken         (ex_taken),
        .i_ex_target        (ex_target),
        .o_flush            (flush),
        .o_redirect_pc      (redirect_pc),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_pred;
        bit          pred;
        bit          chk_flush;
        bit          flush;
        bit          chk_redir;
        logic [31:0] redir;
        bit          chk_cnt;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk_pred)  check({e.name, ".pred"},  {31'd0, pred_taken}, {31'd0, e.pred});
            if (e.chk_flush) check({e.name, ".flush"}, {31'd0, flush},      {31'd0, e.flush});
            if (e.chk_redir) check({e.name, ".redir"}, redirect_pc,         e.redir);
            if (e.chk_cnt) begin
                check({e.name, ".bcnt"}, branch_count,     e.bcnt);
                check({e.name, ".mcnt"}, mispredict_count, e.mcnt);
            end
        end
    end

    // Drive one cycle of stimulus and queue its expected response.
    task automatic step(
        input string name,
        input bit idb, input logic [31:0] idpc,
        input bit exb, input logic [31:0] expc, input bit exp_pred, input bit extk,
        input logic [31:0] tgt, input bit stl,
        input bit cp, input bit ep,
        input bit cf, input bit ef,
        input bit cr, input logic [31:0] er,
        input bit cc, input logic [31:0] ebc, input logic [31:0] emc);
        exp_t e;
        id_branch     = idb;
        id_pc         = idpc;
        ex_branch     = exb;
        ex_pc         = expc;
        ex_pred_taken = exp_pred;
        ex_taken      = extk;
        ex_target     = tgt;
        stall         = stl;
        e.name = name;
        e.chk_pred = cp;  e.pred = ep;
        e.chk_flush = cf; e.flush = ef;
        e.chk_redir = cr; e.redir = er;
        e.chk_cnt = cc;   e.bcnt = ebc; e.mcnt = emc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_branch = 0; id_pc = '0; ex_branch = 0; ex_pc = '0;
        ex_pred_taken = 0; ex_taken = 0; ex_target = '0; stall = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

`ifdef BRANCH_PREDICT_EN
        //    name          idb idpc          exb expc          ep et tgt           st  cp p  cf f  cr redir         cc bc mc
        step("reset",       1, 32'h100,       0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 0, 0);
        step("train1",      0, 32'h0,         1, 32'h100,       0, 1, 32'h180,      0,  0, 0, 1, 1, 1, 32'h180,      1, 0, 0);
        step("train2",      0, 32'h0,         1, 32'h100,       0, 1, 32'h180,      0,  0, 0, 1, 1, 1, 32'h180,      1, 1, 1);
        step("lookup",      1, 32'h100,       0, 32'h0,         0, 0, 32'h0,        0,  1, 1, 1, 0, 1, 32'h0,        1, 2, 2);
        step("mp_nt",       1, 32'h100,       1, 32'h200,       1, 0, 32'h999,      0,  1, 0, 1, 1, 1, 32'h204,      1, 2, 2);
        for (int i = 0; i < 3; i++)
            step("stalled", 1, 32'h100,       1, 32'h300,       0, 1, 32'h80,       1,  1, 1, 1, 0, 1, 32'h0,        1, 3, 3);
        step("release",     1, 32'h100,       1, 32'h300,       0, 1, 32'h80,       0,  1, 0, 1, 1, 1, 32'h80,       1, 3, 3);
        step("idx5_up",     0, 32'h0,         1, 32'h14,        0, 1, 32'h40,       0,  0, 0, 1, 1, 1, 32'h40,       1, 4, 4);
        step("collide",     1, 32'h14,        1, 32'h14,        0, 0, 32'h0,        0,  1, 1, 1, 0, 0, 32'h0,        1, 5, 5);
        step("after_col",   1, 32'h14,        0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 6, 5);
        step("pc_wrap",     0, 32'h0,         1, 32'hFFFFFFFC,  1, 0, 32'h1234,     0,  0, 0, 1, 1, 1, 32'h0,        1, 6, 5);
        step("idle",        0, 32'h0,         0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 7, 6);
`else
        step("reset",       1, 32'h100,       0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 0, 0);
        step("taken1",      1, 32'h100,       1, 32'h100,       0, 1, 32'h300,      0,  1, 0, 1, 1, 1, 32'h300,      1, 0, 0);
        step("taken2",      0, 32'h0,         1, 32'h100,       0, 1, 32'h300,      0,  0, 0, 1, 1, 1, 32'h300,      1, 1, 1);
        step("lookup",      1, 32'h100,       0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 2, 2);
        step("not_taken",   0, 32'h0,         1, 32'h200,       0, 0, 32'h999,      0,  0, 0, 1, 0, 0, 32'h0,        1, 2, 2);
        for (int i = 0; i < 3; i++)
            step("stalled", 1, 32'h100,       1, 32'h300,       0, 1, 32'h80,       1,  1, 0, 1, 0, 1, 32'h0,        1, 3, 2);
        step("release",     0, 32'h0,         1, 32'h300,       0, 1, 32'h80,       0,  0, 0, 1, 1, 1, 32'h80,       1, 3, 2);
        step("idle",        0, 32'h0,         0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 4, 3);
`endif

        // Reset asserted together with a resolving mispredict: reset must win.
        id_branch = 0; ex_branch = 1; ex_pc = 32'h100; ex_pred_taken = 0;
        ex_taken = 1; ex_target = 32'h500; stall = 0; rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        step("post_reset",  1, 32'h100,       0, 32'h0,         0, 0, 32'h0,        0,  1, 0, 1, 0, 1, 32'h0,        1, 0, 0);
        idle();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
